// File: rtl/apb_master_if.sv
// APB bus bundle between the apb_master initiator and a peripheral register block.
interface apb_master_if #(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 16
);
  logic [ADDRESSWIDTH-1:0] PADDR_mst_o;
  logic [DATAWIDTH-1:0]    PWDATA_mst_o;
  logic                    PWRITE_mst_o;
  logic                    PSELx_mst_o;
  logic                    PENABLE_mst_o;
  logic [DATAWIDTH-1:0]    PRDATA_mst_i;
  logic                    PREADY_mst_i;

  modport master (
    output PADDR_mst_o, PWDATA_mst_o, PWRITE_mst_o, PSELx_mst_o, PENABLE_mst_o,
    input  PRDATA_mst_i, PREADY_mst_i
  );

  modport slave (
    input  PADDR_mst_o, PWDATA_mst_o, PWRITE_mst_o, PSELx_mst_o, PENABLE_mst_o,
    output PRDATA_mst_i, PREADY_mst_i
  );
endinterface

// File: rtl/apb_master.sv
// APB initiator: runs one SETUP/ACCESS transfer per host command, with PREADY
// wait states and an optional ACCESS-phase timeout that aborts with an error.
module apb_master #(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 16,
  parameter int TIMEOUT      = 16
) (
  input  logic                    PCLK_mst,
  input  logic                    PRESET_mst,
  input  logic                    cmd_valid_i,
  input  logic                    cmd_write_i,
  input  logic [ADDRESSWIDTH-1:0] cmd_addr_i,
  input  logic [DATAWIDTH-1:0]    cmd_wdata_i,
  output logic                    cmd_ready_o,
  output logic                    rsp_valid_o,
  output logic [DATAWIDTH-1:0]    rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    busy_o,
  apb_master_if.master            apb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Last counter value allowed in ACCESS; only meaningful when TIMEOUT != 0.
  localparam logic [15:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [15:0]             wait_cnt_q, wait_cnt_d;
  logic [ADDRESSWIDTH-1:0] paddr_q, paddr_d;
  logic [DATAWIDTH-1:0]    pwdata_q, pwdata_d;
  logic                    pwrite_q, pwrite_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_LAST);

  always_ff @(posedge PCLK_mst) begin
    if (PRESET_mst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb.PREADY_mst_i || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response fields hold between completions; only rsp_valid defaults low.
  always_comb begin
    wait_cnt_d  = wait_cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid_i) begin
          paddr_d  = cmd_addr_i;
          pwdata_d = cmd_wdata_i;
          pwrite_d = cmd_write_i;
          psel_d   = 1'b1;
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ACCESS: begin
        if (apb.PREADY_mst_i) begin
          rsp_rdata_d = pwrite_q ? '0 : apb.PRDATA_mst_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end else if (timeout_hit) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end else if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready_o       = (state_q == IDLE);
  assign busy_o            = (state_q != IDLE);
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_rdata_o       = rsp_rdata_q;
  assign rsp_err_o         = rsp_err_q;
  assign apb.PADDR_mst_o   = paddr_q;
  assign apb.PWDATA_mst_o  = pwdata_q;
  assign apb.PWRITE_mst_o  = pwrite_q;
  assign apb.PSELx_mst_o   = psel_q;
  assign apb.PENABLE_mst_o = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed table, random transfers against a
// transaction-level model, and hand-written back-to-back / reset / no-timeout sequences.
module tb_apb_master;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst;
  logic          cmd_valid, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_ready, rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;

  logic          nt_cmd_valid, nt_cmd_write;
  logic [AW-1:0] nt_cmd_addr;
  logic [DW-1:0] nt_cmd_wdata;
  logic          nt_cmd_ready, nt_rsp_valid, nt_rsp_err, nt_busy;
  logic [DW-1:0] nt_rsp_rdata;

  apb_master_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) bus ();
  apb_master_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) bus_nt ();

  apb_master #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK_mst   (clk),
    .PRESET_mst (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_write_i(cmd_write),
    .cmd_addr_i (cmd_addr),
    .cmd_wdata_i(cmd_wdata),
    .cmd_ready_o(cmd_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o  (rsp_err),
    .busy_o     (busy),
    .apb        (bus)
  );

  apb_master #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(0)) dut_nt (
    .PCLK_mst   (clk),
    .PRESET_mst (rst),
    .cmd_valid_i(nt_cmd_valid),
    .cmd_write_i(nt_cmd_write),
    .cmd_addr_i (nt_cmd_addr),
    .cmd_wdata_i(nt_cmd_wdata),
    .cmd_ready_o(nt_cmd_ready),
    .rsp_valid_o(nt_rsp_valid),
    .rsp_rdata_o(nt_rsp_rdata),
    .rsp_err_o  (nt_rsp_err),
    .busy_o     (nt_busy),
    .apb        (bus_nt)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] prdata;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_access;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: a transfer either completes after its wait
  // states or is cut off once TIMEOUT ACCESS cycles have passed.
  function automatic logic model_err(input int waits);
    return (TO != 0) && (waits >= TO);
  endfunction

  function automatic logic [DW-1:0] model_rdata(input logic wr, input int waits, input logic [DW-1:0] prdata);
    if (model_err(waits) || wr) return '0;
    return prdata;
  endfunction

  function automatic int model_access(input int waits);
    return model_err(waits) ? TO : waits + 1;
  endfunction

  // Issues one command on the TIMEOUT=4 instance and plays the slave side,
  // holding PREADY low for 'waits' ACCESS cycles before raising it.
  task automatic applyStimulus(input vec_t v);
    int n;
    int guard;
    logic bus_stable;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    bus.PREADY_mst_i = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    checkOutput("setup_psel",    bus.PSELx_mst_o,   1);
    checkOutput("setup_penable", bus.PENABLE_mst_o, 0);
    checkOutput("setup_ready",   cmd_ready,         0);
    checkOutput("setup_busy",    busy,              1);
    checkOutput("setup_bus", {bus.PWRITE_mst_o, bus.PADDR_mst_o, bus.PWDATA_mst_o},
                {v.wr, v.addr, v.wdata});
    n = 0;
    bus_stable = 1'b1;
    @(negedge clk);
    while (bus.PSELx_mst_o && bus.PENABLE_mst_o && n < 300) begin
      if ({bus.PWRITE_mst_o, bus.PADDR_mst_o, bus.PWDATA_mst_o} !== {v.wr, v.addr, v.wdata} ||
          rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
        bus_stable = 1'b0;
      n++;
      bus.PREADY_mst_i = (n == v.waits + 1);
      bus.PRDATA_mst_i = (n == v.waits + 1) ? v.prdata : DW'($urandom);
      @(negedge clk);
    end
    bus.PREADY_mst_i = 1'b0;
    checkOutput("access_stable", bus_stable,  1);
    checkOutput("access_cycles", n,           v.exp_access);
    checkOutput("rsp_valid",     rsp_valid,   1);
    checkOutput("rsp_err",       rsp_err,     v.exp_err);
    checkOutput("rsp_rdata",     rsp_rdata,   v.exp_rdata);
    checkOutput("done_psel",     {bus.PSELx_mst_o, bus.PENABLE_mst_o}, 0);
    checkOutput("done_ready",    cmd_ready,   1);
    @(negedge clk);
    checkOutput("rsp_pulse",     rsp_valid,   0);
    checkOutput("rsp_hold",      {rsp_err, rsp_rdata}, {v.exp_err, v.exp_rdata});
  endtask

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    int   setups[$];
    logic [DW-1:0] rsps[$];
    logic ready_bad;
    logic second_pwrite;
    logic saw_rsp;
    int   n;

    vecs[0] = '{1'b1, 3'd1, 16'h00A5, 0,  16'h0000, 1'b0, 16'h0000, 1};
    vecs[1] = '{1'b0, 3'd5, 16'h0000, 3,  16'h0080, 1'b0, 16'h0080, 4};
    vecs[2] = '{1'b0, 3'd3, 16'h0000, 50, 16'hBEEF, 1'b1, 16'h0000, 4};
    vecs[3] = '{1'b1, 3'd4, 16'hFFFF, 3,  16'h1111, 1'b0, 16'h0000, 4};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 4,  16'h5555, 1'b1, 16'h0000, 4};
    vecs[5] = '{1'b0, 3'd7, 16'h0000, 0,  16'hC3C3, 1'b0, 16'hC3C3, 1};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    nt_cmd_valid = 1'b0; nt_cmd_write = 1'b0; nt_cmd_addr = '0; nt_cmd_wdata = '0;
    bus.PREADY_mst_i = 1'b0; bus.PRDATA_mst_i = '0;
    bus_nt.PREADY_mst_i = 1'b0; bus_nt.PRDATA_mst_i = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", cmd_ready, 1);
    checkOutput("reset_busy",  busy,      0);
    checkOutput("reset_rsp",   {rsp_valid, rsp_err, rsp_rdata}, 0);
    checkOutput("reset_bus", {bus.PSELx_mst_o, bus.PENABLE_mst_o, bus.PWRITE_mst_o,
                              bus.PADDR_mst_o, bus.PWDATA_mst_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      v.wr         = 1'($urandom);
      v.addr       = AW'($urandom);
      v.wdata      = DW'($urandom);
      v.waits      = $urandom_range(0, 6);
      v.prdata     = DW'($urandom);
      v.exp_err    = model_err(v.waits);
      v.exp_rdata  = model_rdata(v.wr, v.waits, v.prdata);
      v.exp_access = model_access(v.waits);
      applyStimulus(v);
    end

    // Back-to-back: valid held high across a write then a read to address 2.
    ready_bad = 1'b0;
    second_pwrite = 1'b1;
    bus.PREADY_mst_i = 1'b1;
    bus.PRDATA_mst_i = 16'h1234;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 16'h0F0F;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.PSELx_mst_o && !bus.PENABLE_mst_o) begin
        setups.push_back(cyc);
        if (setups.size() == 1) cmd_write = 1'b0;
        else begin
          cmd_valid = 1'b0;
          second_pwrite = bus.PWRITE_mst_o;
        end
      end
      if ((bus.PSELx_mst_o || busy) && cmd_ready) ready_bad = 1'b1;
      if (rsp_valid) rsps.push_back(rsp_rdata);
    end
    bus.PREADY_mst_i = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("b2b_setups", setups.size(), 2);
    checkOutput("b2b_gap", (setups.size() >= 2) ? setups[1] - setups[0] : -1, 3);
    checkOutput("b2b_ready_busy", ready_bad, 0);
    checkOutput("b2b_second_read", second_pwrite, 0);
    checkOutput("b2b_rsps", rsps.size(), 2);
    checkOutput("b2b_wr_rdata", (rsps.size() >= 1) ? rsps[0] : 16'hDEAD, 16'h0000);
    checkOutput("b2b_rd_rdata", (rsps.size() >= 2) ? rsps[1] : 16'hDEAD, 16'h1234);

    // Reset pulsed while the slave is inserting wait states.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_pre_access", bus.PENABLE_mst_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_bus", {bus.PSELx_mst_o, bus.PENABLE_mst_o}, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    saw_rsp = rsp_valid;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    checkOutput("rst_no_rsp", saw_rsp, 0);

    // TIMEOUT=0 instance: 100 wait states then completion, no abort.
    nt_cmd_valid = 1'b1; nt_cmd_write = 1'b0; nt_cmd_addr = 3'd6; nt_cmd_wdata = '0;
    @(negedge clk);
    nt_cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus_nt.PSELx_mst_o && bus_nt.PENABLE_mst_o && n < 400) begin
      n++;
      bus_nt.PREADY_mst_i = (n == 101);
      bus_nt.PRDATA_mst_i = (n == 101) ? 16'h7E57 : DW'($urandom);
      @(negedge clk);
    end
    bus_nt.PREADY_mst_i = 1'b0;
    checkOutput("nt_access_cycles", n, 101);
    checkOutput("nt_rsp_valid", nt_rsp_valid, 1);
    checkOutput("nt_rsp_err",   nt_rsp_err,   0);
    checkOutput("nt_rsp_rdata", nt_rsp_rdata, 16'h7E57);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
